// File: rtl/stopwatch_mmss.sv
// BCD mm:ss stopwatch driven by the 1 s divider square wave, with start/stop/clear control
// and registered 7-segment outputs. Define STOPWATCH_ALARM_EN to build the alarm comparator.
module stopwatch_mmss #(
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int MAX_MIN_TENS   = 5
) (
  input  logic        clock_50M,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [15:0] alarm_time,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        rollover,
  output logic        alarm,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam logic [3:0] MIN_TENS_TOP = 4'(MAX_MIN_TENS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  state_t     state, state_next;
  logic       tick_q;
  logic       tick_rise;
  logic       inc;
  logic       full_wrap;
  logic [3:0] so_nx, st_nx, mo_nx, mt_nx;

  // Active-low segment pattern {g,f,e,d,c,b,a}; unused codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? s : ~s;
  endfunction

  assign tick_rise = tick_in & ~tick_q;
  assign inc       = (state == ST_RUN) & tick_rise & ~stop & ~clear;

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start && !stop) state_next = ST_RUN;
        ST_RUN:   if (stop) state_next = ST_PAUSE;
        ST_PAUSE: if (start && !stop) state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // BCD ripple: each digit wraps only when every lower digit wraps too.
  always_comb begin
    so_nx     = sec_ones;
    st_nx     = sec_tens;
    mo_nx     = min_ones;
    mt_nx     = min_tens;
    full_wrap = 1'b0;
    if (sec_ones == 4'd9) begin
      so_nx = '0;
      if (sec_tens == 4'd5) begin
        st_nx = '0;
        if (min_ones == 4'd9) begin
          mo_nx = '0;
          if (min_tens == MIN_TENS_TOP) begin
            mt_nx     = '0;
            full_wrap = 1'b1;
          end else begin
            mt_nx = min_tens + 4'd1;
          end
        end else begin
          mo_nx = min_ones + 4'd1;
        end
      end else begin
        st_nx = sec_tens + 4'd1;
      end
    end else begin
      so_nx = sec_ones + 4'd1;
    end
  end

  always_ff @(posedge clock_50M) begin
    tick_q <= tick_in;
    if (!reset) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      rollover <= 1'b0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
    end else begin
      state    <= state_next;
      running  <= (state_next == ST_RUN);
      rollover <= inc & full_wrap;
      if (clear) begin
        sec_ones <= '0;
        sec_tens <= '0;
        min_ones <= '0;
        min_tens <= '0;
      end else if (inc) begin
        sec_ones <= so_nx;
        sec_tens <= st_nx;
        min_ones <= mo_nx;
        min_tens <= mt_nx;
      end
    end
  end

  always_ff @(posedge clock_50M) begin
    if (!reset) begin
      hex0 <= seg7(4'd0);
      hex1 <= seg7(4'd0);
      hex2 <= seg7(4'd0);
      hex3 <= seg7(4'd0);
    end else begin
      hex0 <= seg7(sec_ones);
      hex1 <= seg7(sec_tens);
      hex2 <= seg7(min_ones);
      hex3 <= seg7(min_tens);
    end
  end

`ifdef STOPWATCH_ALARM_EN
  logic alarm_hit;

  // Compared against the post-increment digits so alarm rises with the matching update.
  assign alarm_hit = inc & ({mt_nx, mo_nx, st_nx, so_nx} == alarm_time);

  always_ff @(posedge clock_50M) begin
    if (!reset) begin
      alarm <= 1'b0;
    end else if (clear) begin
      alarm <= 1'b0;
    end else if (alarm_hit) begin
      alarm <= 1'b1;
    end
  end
`else
  logic unused_alarm_time;

  assign unused_alarm_time = ^alarm_time;
  assign alarm             = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Randomized and directed bench for stopwatch_mmss against a seconds-count reference model.
module tb_stopwatch_mmss;

  localparam int SEG_ACTIVE_LOW = 1;
  localparam int MAX_MIN_TENS   = 5;
  localparam int WRAP           = (MAX_MIN_TENS + 1) * 600;
`ifdef STOPWATCH_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic        clock_50M = 1'b0;
  logic        reset, tick_in, start, stop, clear;
  logic [15:0] alarm_time;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic        running, rollover, alarm;
  logic [6:0]  hex0, hex1, hex2, hex3;

  always #10 clock_50M = ~clock_50M;

  stopwatch_mmss #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW),
    .MAX_MIN_TENS  (MAX_MIN_TENS)
  ) dut (
    .clock_50M (clock_50M),
    .reset     (reset),
    .tick_in   (tick_in),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .alarm_time(alarm_time),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .running   (running),
    .rollover  (rollover),
    .alarm     (alarm),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: elapsed seconds as a plain integer, mode 0=idle 1=run 2=pause.
  int m_total = 0;
  int m_mode  = 0;
  bit m_tick_q = 1'b0;
  bit m_roll  = 1'b0;
  bit m_alarm = 1'b0;

  function automatic logic [15:0] to_bcd(input int t);
    logic [3:0] mt, mo, st, so;
    mt = 4'(t / 600);
    mo = 4'((t / 60) % 10);
    st = 4'((t % 60) / 10);
    so = 4'(t % 10);
    return {mt, mo, st, so};
  endfunction

  function automatic int bcd_to_secs(input logic [15:0] b);
    return int'(b[15:12]) * 600 + int'(b[11:8]) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [6:0] seg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;
      1: s = 7'b1111001;
      2: s = 7'b0100100;
      3: s = 7'b0110000;
      4: s = 7'b0011001;
      5: s = 7'b0010010;
      6: s = 7'b0000010;
      7: s = 7'b1111000;
      8: s = 7'b0000000;
      9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  function automatic logic [27:0] hex_of(input int t);
    return {seg(t / 600), seg((t / 60) % 10), seg((t % 60) / 10), seg(t % 10)};
  endfunction

  task automatic step();
    int prev;
    bit rise, inc, rst_n;
    prev  = m_total;
    rst_n = reset;
    rise  = tick_in && !m_tick_q;
    if (!reset) begin
      m_total = 0; m_mode = 0; m_roll = 0; m_alarm = 0;
    end else begin
      inc    = (m_mode == 1) && rise && !stop && !clear;
      m_roll = 0;
      if (clear) begin
        m_mode = 0; m_total = 0; m_alarm = 0;
      end else begin
        if (inc) begin
          m_total = (m_total + 1) % WRAP;
          m_roll  = (m_total == 0);
          if (ALARM_EN && m_total == bcd_to_secs(alarm_time)) m_alarm = 1;
        end
        if (stop) begin
          if (m_mode == 1) m_mode = 2;
        end else if (start) begin
          m_mode = 1;
        end
      end
    end
    m_tick_q = tick_in;
    @(posedge clock_50M);
    #1;
    check("digits", {min_tens, min_ones, sec_tens, sec_ones}, to_bcd(m_total));
    check("running", running, m_mode == 1);
    check("rollover", rollover, m_roll);
    check("alarm", alarm, m_alarm);
    check("hex", {hex3, hex2, hex1, hex0}, rst_n ? hex_of(prev) : hex_of(0));
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_in = 1'b1; step();
      tick_in = 1'b0; step();
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  logic [6:0] zero_seg;

  initial begin
    zero_seg   = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
    reset      = 1'b0;
    tick_in    = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    clear      = 1'b0;
    alarm_time = 16'h0003;

    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_hex", {hex3, hex2, hex1, hex0}, {4{zero_seg}});
    tick_in = 1'b0;
    step();

    pulse_start();
    tick_n(10);
    check("ten_sec", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0010);

    pulse_clear();
    pulse_start();
    tick_n(358);
    check("preload", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0558);
    tick_n(2);
    check("carry_min", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0600);
    tick_n(3599 - 360);
    check("top", {min_tens, min_ones, sec_tens, sec_ones}, 16'h5959);
    tick_in = 1'b1;
    step();
    check("wrap_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("wrap_pulse", rollover, 1'b1);
    check("wrap_running", running, 1'b1);
    tick_in = 1'b0;
    step();
    check("wrap_pulse_end", rollover, 1'b0);

    pulse_clear();
    pulse_start();
    tick_n(7);
    check("at7", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0007);
    tick_in = 1'b1; stop = 1'b1; step();
    tick_in = 1'b0; stop = 1'b0; step();
    check("stop_tick", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0007);
    check("paused", running, 1'b0);
    tick_n(3);
    check("pause_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0007);
    start = 1'b1; tick_in = 1'b1; step();
    start = 1'b0; tick_in = 1'b0; step();
    check("start_tick", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0007);
    check("resumed", running, 1'b1);
    tick_n(1);
    check("after_resume", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0008);
    pulse_clear();
    check("clr_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("clr_idle", running, 1'b0);

    alarm_time = 16'h0003;
    pulse_start();
    tick_n(2);
    check("alarm_early", alarm, 1'b0);
    tick_in = 1'b1; step();
    check("alarm_set", alarm, ALARM_EN);
    tick_in = 1'b0; stop = 1'b1; step(); stop = 1'b0;
    check("alarm_after_stop", alarm, ALARM_EN);
    pulse_clear();
    check("alarm_cleared", alarm, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      clear = ($urandom_range(0, 49) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) < 3) tick_in = ~tick_in;
      if ($urandom_range(0, 299) == 0) alarm_time = to_bcd($urandom_range(0, 150));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_mmss.md
Name: stopwatch_mmss

Overview:
- Consumes the slow square wave from the 50 MHz clock divider (one toggle period = 1 s) and runs a BCD mm:ss stopwatch with start/stop/clear control.
- Drives four 7-segment digit outputs for the board display.
- Runs entirely in the clock_50M domain. The slow wave is sampled as data and is never used as a clock.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (board default); 0 = active-high.
- MAX_MIN_TENS, 5, highest minutes-tens digit before wrap. Legal range 1..9.

Ports:
- clock_50M  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-low reset
- tick_in  input  1  divider square-wave output, synchronous to clock_50M
- start  input  1  start/resume command, level-sampled each cycle
- stop  input  1  pause command, level-sampled
- clear  input  1  zero and idle command, level-sampled
- alarm_time  input  16  BCD {min_tens,min_ones,sec_tens,sec_ones}; used only with ALARM_EN
- sec_ones  output  4  BCD
- sec_tens  output  4  BCD, 0..5
- min_ones  output  4  BCD
- min_tens  output  4  BCD, 0..MAX_MIN_TENS
- running  output  1  high in RUN state
- rollover  output  1  one-cycle pulse on wrap to 00:00
- alarm  output  1  sticky alarm flag
- hex0..hex3  output  7 each  segments {g,f,e,d,c,b,a}; hex0 = sec_ones … hex3 = min_tens

Behaviour:
- All logic is on posedge clock_50M. Reset is sampled only at the clock edge.
- Reset (reset==0) values:
  - state = IDLE; all digits 0; running 0; rollover 0; alarm 0.
  - hex0..hex3 show "0": 7'b1000000 when SEG_ACTIVE_LOW=1.
  - tick_q <= tick_in, so no false edge is produced when reset is released while tick_in is high.
- Edge detect:
  - tick_q is a register of tick_in.
  - tick_rise = tick_in & ~tick_q.
  - Exactly one increment per tick_in rising edge, i.e. one per second.
- Command priority: clear > stop > start.
- FSM states:
  - IDLE: start -> RUN. stop is ignored.
  - RUN: stop -> PAUSE. tick_rise with no stop/clear in the same cycle -> increment.
  - PAUSE: start -> RUN. Digits are held.
  - clear in any state -> IDLE with digits zeroed on the next edge. clear also drops alarm.
- Simultaneous events:
  - tick_rise in the same cycle as stop or clear: no increment.
  - tick_rise in the same cycle as a start leaving IDLE or PAUSE: not counted. Counting begins at the next rising edge.
- Increment arithmetic, BCD ripple:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens MAX_MIN_TENS -> 0 only when every lower digit also wraps.
  - Full wrap (5 9:5 9 -> 00:00 at default) pulses rollover high for exactly one cycle. The block stays in RUN.
- Latency:
  - Digits update on the clock edge after the cycle in which tick_rise is high.
  - hex outputs are registered and lag the digits by one further cycle.
- 7-seg decode:
  - Standard 0-9 patterns, inverted when SEG_ACTIVE_LOW=0.
  - Codes 10-15 cannot occur; if they do, the digit is blanked (all segments off).
- running equals (state==RUN) and is registered with the state.
- Holding start, stop or clear high for many cycles is legal:
  - Held start keeps RUN.
  - Held stop keeps PAUSE.
  - Held clear keeps IDLE at 00:00.

Optional Feature:
- Macro: STOPWATCH_ALARM_EN.
- Defined:
  - When an increment produces digits equal to alarm_time, alarm is set high on the same edge as the digit update.
  - alarm stays high until clear or reset. A stop does not drop it.
  - An alarm_time of 00:00 matches only when a rollover occurs.
- Not defined:
  - alarm_time is ignored and alarm is tied to 0.
  - No comparator logic is synthesised.

Test Plan:
- Reset low for 3 cycles, then high, with tick_in=1 during reset -> digits 00:00, running=0, hex0..hex3=7'b1000000, and no increment on the first cycle after release.
- start 1 cycle, then 10 tick_in rising edges -> sec_tens=1, sec_ones=0. Each increment lands exactly 1 cycle after the edge cycle, and hex0 follows one cycle later.
- Preload to 05:58 via 358 ticks in RUN, then 2 more ticks -> 06:00, with the sec_tens->min_ones carry correct.
- Run to 59:59, then one tick -> 00:00, rollover high for exactly 1 cycle, running stays 1.
- stop asserted in the same cycle as tick_rise at 00:07 -> holds 00:07 in PAUSE through 3 further ticks. A following start is not counted, and the next tick gives 00:08. clear then gives 00:00 and IDLE.
- With STOPWATCH_ALARM_EN, alarm_time=16'h0003 -> alarm rises on the edge where the digits become 00:03, stays high after stop, and drops on clear. Without the macro, alarm stays 0 throughout.
